// File: rtl/load_ext_pkg.sv
// -----------------------------------------------------------------------------
// load_ext_pkg
// Shared definitions for the load-data extract/extend pipeline:
//   - access-size encodings used on in_size
//   - width of the saturating address-error counter
//   - is_misaligned(): decides whether an access violates natural alignment
// -----------------------------------------------------------------------------
package load_ext_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam int ERR_CNT_W = 16;

    // The offset is passed zero-extended to 3 bits so one function serves
    // both datapath widths. A dword access on a 32-bit datapath cannot be
    // satisfied, so it is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] off,
                                           input int         data_w);
        logic r;
        case (size)
            SZ_BYTE:  r = 1'b0;
            SZ_HALF:  r = off[0];
            SZ_WORD:  r = (off[1:0] != 2'b00);
            SZ_DWORD: r = (data_w != 64) || (off != 3'b000);
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_ext_pipe_ext_field.sv
// -----------------------------------------------------------------------------
// ext_field
// Combinational sign/zero extender. The field arrives already shifted down to
// bit 0; bits above the access size are replaced by the field MSB (i_sign=1)
// or by zeros (i_sign=0). A full-width access passes through untouched.
// Ports:
//   i_field  DATA_W  right-aligned field
//   i_size   2       access size (byte/half/word/dword)
//   i_sign   1       1 = sign extend, 0 = zero extend
//   o_ext    DATA_W  extended value
// -----------------------------------------------------------------------------
module ext_field
    import load_ext_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_field,
    input  logic [1:0]        i_size,
    input  logic              i_sign,
    output logic [DATA_W-1:0] o_ext
);

    logic [6:0]        w_nbits;
    logic [DATA_W-1:0] w_mask;
    logic              w_msb;

    // Field-width mask and field sign bit for the requested size
    always_comb begin
        w_nbits = 7'd8 << i_size;
        // A shift by >= DATA_W yields zero, so full-width sizes get an all-ones mask
        w_mask  = ~({DATA_W{1'b1}} << w_nbits);
        case (i_size)
            SZ_BYTE:  w_msb = i_field[7];
            SZ_HALF:  w_msb = i_field[15];
            SZ_WORD:  w_msb = i_field[31];
            SZ_DWORD: w_msb = i_field[DATA_W-1];
            default:  w_msb = 1'b0;
        endcase
    end

    assign o_ext = (i_field & w_mask) | ({DATA_W{i_sign & w_msb}} & ~w_mask);

endmodule

// File: rtl/load_ext_pipe.sv
// -----------------------------------------------------------------------------
// load_ext_pipe
// Two-stage load-data extractor between the data-memory read port and the
// writeback register. Stage 1 shifts the addressed field down and flags
// misalignment; stage 2 extends the field to full width. Valid/ready flow
// control lets the surrounding pipeline stall (out_ready=0) or kill (flush)
// in-flight beats.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop every in-flight entry (highest priority)
//   in_valid/in_ready   input handshake; in_ready depends on out_ready only
//   in_data/off/size/sign/tag   raw word, byte offset, size, signedness, tag
//   out_valid/out_ready output handshake
//   out_data/tag/adel   extended result, tag, address-error flag
//   err_cnt             saturating count of delivered address errors
// -----------------------------------------------------------------------------
module load_ext_pipe
    import load_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8),
    parameter int TAG_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [OFF_W-1:0]     in_off,
    input  logic [1:0]           in_size,
    input  logic                 in_sign,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_adel,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Stage 1 state
    logic               r_v1;
    logic [DATA_W-1:0]  r_s1_field;
    logic [1:0]         r_s1_size;
    logic               r_s1_sign;
    logic [TAG_W-1:0]   r_s1_tag;
    logic               r_s1_adel;

    // Stage 2 state
    logic               r_v2;
    logic [DATA_W-1:0]  r_s2_data;
    logic [TAG_W-1:0]   r_s2_tag;
    logic               r_s2_adel;

    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic               w_adv1;
    logic               w_adv2;
    logic [2:0]         w_off3;
    logic               w_s1_adel;
    logic [DATA_W-1:0]  w_shift;
    logic [DATA_W-1:0]  w_s1_field;
    logic [DATA_W-1:0]  w_ext;

    // A stage may load when it is empty or its content moves on this cycle
    assign w_adv2   = !r_v2 || out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign in_ready = w_adv1;

    assign w_off3     = 3'(in_off);
    assign w_s1_adel  = is_misaligned(in_size, w_off3, DATA_W);
    assign w_shift    = in_data >> {in_off, 3'b000};
    // Misaligned beats carry a zero field so the result is zero by construction
    assign w_s1_field = w_s1_adel ? {DATA_W{1'b0}} : w_shift;

    ext_field #(
        .DATA_W (DATA_W)
    ) u_ext_field (
        .i_field (r_s1_field),
        .i_size  (r_s1_size),
        .i_sign  (r_s1_sign),
        .o_ext   (w_ext)
    );

    // Pipeline registers: reset clears everything, flush only kills valids
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_s1_field <= {DATA_W{1'b0}};
            r_s1_size  <= 2'b00;
            r_s1_sign  <= 1'b0;
            r_s1_tag   <= {TAG_W{1'b0}};
            r_s1_adel  <= 1'b0;
            r_v2       <= 1'b0;
            r_s2_data  <= {DATA_W{1'b0}};
            r_s2_tag   <= {TAG_W{1'b0}};
            r_s2_adel  <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_s2_data <= r_s1_adel ? {DATA_W{1'b0}} : w_ext;
                    r_s2_tag  <= r_s1_tag;
                    r_s2_adel <= r_s1_adel;
                end
            end
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_s1_field <= w_s1_field;
                    r_s1_size  <= in_size;
                    r_s1_sign  <= in_sign;
                    r_s1_tag   <= in_tag;
                    r_s1_adel  <= w_s1_adel;
                end
            end
        end
    end

    // Saturating count of address errors actually handed to the consumer;
    // a handshake in a flush cycle still completes, so it still counts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= {ERR_CNT_W{1'b0}};
        end else if (r_v2 && out_ready && r_s2_adel && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign out_valid = r_v2;
    assign out_data  = r_s2_data;
    assign out_tag   = r_s2_tag;
    assign out_adel  = r_s2_adel;
    assign err_cnt   = r_err_cnt;

endmodule

// File: doc/load_ext_pipe.md
# load_ext_pipe

Parametrised, pipelined load-data extractor and extender for the memory-writeback path. It takes a raw data-memory word plus byte offset, access size and signedness. It then selects the addressed byte, halfword, word or doubleword and sign- or zero-extends it to full width. Misaligned accesses are flagged as an address-error and counted. It sits between the data-memory read port and the writeback register, with valid/ready flow control so the pipeline can stall or flush it.

## Interface
- DATA_W, 32, datapath width in bits; legal values are 32 and 64.
- OFF_W, $clog2(DATA_W/8), byte-offset width (2 for 32-bit, 3 for 64-bit).
- TAG_W, 5, width of the destination-register tag carried alongside the data.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kills every in-flight entry; has priority over all other events.
- in_valid  in  1  the input beat is present.
- in_ready  out  1  the block accepts the input beat this cycle.
- in_data  in  DATA_W  raw memory word, little-endian.
- in_off  in  OFF_W  byte offset of the access within in_data.
- in_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- in_sign  in  1  1 selects sign extension, 0 selects zero extension.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  the result is present.
- out_ready  in  1  the consumer takes the result.
- out_data  out  DATA_W  extended result.
- out_tag  out  TAG_W  tag of the result.
- out_adel  out  1  address-error flag for the result.
- err_cnt  out  16  saturating count of delivered address errors.

## Operation
- Byte k of the memory word is in_data[8k+7:8k]. The selected field starts at byte in_off and spans 2^in_size bytes.
- Extension: the field's MSB is replicated into the upper bits when in_sign=1; the upper bits are zero when in_sign=0. A full-width access passes through unchanged, ignoring in_sign.
- Misalignment rules:
  - half with in_off[0]≠0;
  - word with in_off[1:0]≠0;
  - dword with in_off≠0;
  - in_size=3 when DATA_W=32 is illegal and is treated as misaligned.
- Misaligned result: out_adel=1 and out_data=0.
- Stage 1 (S1) registers the shifted field, size, sign, tag and adel. Stage 2 (S2) registers the extended data, tag and adel.
- err_cnt increments by 1 on each cycle with out_valid&out_ready&out_adel. It holds at 16'hFFFF once saturated and is not cleared by flush.

## Timing
- Latency is 2 cycles from input acceptance to out_valid. Throughput is one beat per cycle when out_ready=1.
- Stage advance conditions:
  - adv2 = !v2 | out_ready;
  - adv1 = !v1 | adv2;
  - in_ready = adv1.
- in_ready is combinational from out_ready; there is no other combinational input-to-output path.
- A stage that does not advance holds its contents. out_data, out_tag and out_adel are stable while out_valid&!out_ready.
- flush: v1 and v2 are 0 on the next edge. A beat presented during a flush cycle is discarded even if in_ready=1. The counter still counts a handshake that completes in the same cycle as a flush.
- rst: v1=0, v2=0, out_valid=0, out_data=0, out_tag=0, out_adel=0, err_cnt=0. in_ready reads 1 from the first cycle after reset.
- Reset asserted mid-stream drops all entries, identically to flush, and also clears err_cnt.
- A full pipeline (v1=v2=1) with out_ready=0 deasserts in_ready. When out_ready rises, both stages shift and a new beat is accepted in the same cycle.

## Structure
- Package load_ext_pkg holds:
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3;
  - the misalignment function;
  - the ERR_CNT_W=16 constant.
- Sub-module ext_field (combinational): inputs are the field, size and sign; output is the DATA_W extended value. It is instantiated in stage 2.
- The top level holds both pipeline stages, the handshake logic and err_cnt.

## Test plan
- DATA_W=32, in_data=32'h8070_FF12:
  - off=1, byte, sign=1 → out_data=32'hFFFF_FFFF, adel=0, 2 cycles after acceptance;
  - same with sign=0 → 32'h0000_00FF.
- DATA_W=32, in_data=32'h8070_FF12:
  - off=2, half, sign=1 → 32'hFFFF_8070;
  - off=1, half → adel=1, out_data=0, err_cnt=1.
- DATA_W=64, in_data=64'h8000_0001_7FFF_FFFF:
  - off=4, word, sign=1 → 64'hFFFF_FFFF_8000_0001;
  - off=0, dword → passthrough;
  - size=3 with DATA_W=32 → adel=1.
- Backpressure: stream 4 beats with out_ready=0 for 3 cycles.
  - in_ready drops after 2 beats are accepted.
  - All 4 results emerge in order with correct tags and none are lost or duplicated.
- Flush with v1=v2=1 and in_valid=1 → out_valid=0 next cycle. Neither held beat nor the new beat ever appears; err_cnt is unchanged.
- Counter saturation: force 65 537 misaligned deliveries → err_cnt=16'hFFFF and holds. rst then gives err_cnt=0 and all outputs 0 on the next cycle.
